// File: rtl/nic8_out_display.sv
// Output-port display for the nic8 CPU: captures each "out" byte, converts it to
// three BCD digits with a sequential double-dabble engine and scans a 3-digit 7-segment display.
module nic8_out_display #(
    parameter int SCAN_DIV      = 1024,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_strobe,
    input  logic [7:0]  out_data,
    output logic        busy,
    output logic        valid,
    output logic [11:0] bcd,
    output logic        overrun,
    output logic [6:0]  seg,
    output logic [2:0]  digit_en
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t           state, stateNext;
    logic [19:0]      shiftReg;
    logic [2:0]       shiftCnt;
    logic             pendFull;
    logic [7:0]       pendData;
    logic [11:0]      bcdReg;
    logic             validReg;
    logic             overrunReg;
    logic [DIV_W-1:0] divCnt;
    logic [2:0]       digitEn;

    logic             loadEngine;
    logic [7:0]       loadSrc;
    logic             pendWrite;
    logic             pendClear;
    logic             setOverrun;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabbleStep(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] segDecode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        stateNext  = state;
        loadEngine = 1'b0;
        loadSrc    = out_data;
        pendWrite  = 1'b0;
        pendClear  = 1'b0;
        setOverrun = 1'b0;
        case (state)
            IDLE: begin
                if (out_strobe) begin
                    loadEngine = 1'b1;
                    stateNext  = CONVERT;
                end
            end
            CONVERT: begin
                if (shiftCnt == 3'd7)
                    stateNext = UPDATE;
                if (out_strobe) begin
                    pendWrite  = 1'b1;
                    setOverrun = pendFull;
                end
            end
            UPDATE: begin
                // A queued byte goes first; a simultaneous strobe refills the queue.
                if (pendFull) begin
                    loadEngine = 1'b1;
                    loadSrc    = pendData;
                    stateNext  = CONVERT;
                    if (out_strobe) pendWrite = 1'b1;
                    else            pendClear = 1'b1;
                end else if (out_strobe) begin
                    loadEngine = 1'b1;
                    stateNext  = CONVERT;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shiftCnt   <= 3'd0;
            pendFull   <= 1'b0;
            overrunReg <= 1'b0;
            bcdReg     <= 12'h000;
            validReg   <= 1'b0;
        end else begin
            state    <= stateNext;
            validReg <= (state == UPDATE);
            if (state == UPDATE)
                bcdReg <= shiftReg[19:8];
            if (loadEngine)
                shiftCnt <= 3'd0;
            else if (state == CONVERT)
                shiftCnt <= shiftCnt + 3'd1;
            if (pendWrite)
                pendFull <= 1'b1;
            else if (pendClear)
                pendFull <= 1'b0;
            if (setOverrun)
                overrunReg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (loadEngine)
            shiftReg <= {12'h000, loadSrc};
        else if (state == CONVERT)
            shiftReg <= dabbleStep(shiftReg);
        if (pendWrite)
            pendData <= out_data;
    end

    // Display scan runs freely, unrelated to the conversion engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt  <= '0;
            digitEn <= 3'b001;
        end else if (divCnt == DIV_LAST) begin
            divCnt  <= '0;
            digitEn <= {digitEn[1:0], digitEn[2]};
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    always_comb begin
        logic [3:0] nib;
        logic       blank;
        nib   = bcdReg[3:0];
        blank = 1'b0;
        case (digitEn)
            3'b010: begin
                nib   = bcdReg[7:4];
                blank = (BLANK_LEADING != 0) && (bcdReg[11:8] == 4'd0) && (bcdReg[7:4] == 4'd0);
            end
            3'b100: begin
                nib   = bcdReg[11:8];
                blank = (BLANK_LEADING != 0) && (bcdReg[11:8] == 4'd0);
            end
            default: nib = bcdReg[3:0];
        endcase
        seg = blank ? 7'h00 : segDecode(nib);
    end

    assign busy     = (state != IDLE);
    assign valid    = validReg;
    assign bcd      = bcdReg;
    assign overrun  = overrunReg;
    assign digit_en = digitEn;

endmodule
